// File: rtl/mem_port_arbiter_if.sv
// Two-requester memory port bundle: requester-side fields, grants/responses and
// the single downstream port. Signal suffixes are relative to the arbiter.
interface mem_port_arbiter_if #(
  parameter int NBIT_AXI_WIDTH = 64,
  parameter int USER_AXI_WIDTH = 10
);
  logic [1:0]                      req_i;
  logic [1:0]                      we_i;
  logic [1:0]                      lock_i;
  logic [2*NBIT_AXI_WIDTH/8-1:0]   be_i;
  logic [2*NBIT_AXI_WIDTH-1:0]     addr_i;
  logic [2*NBIT_AXI_WIDTH-1:0]     wdata_i;
  logic [2*USER_AXI_WIDTH-1:0]     user_i;
  logic [1:0]                      gnt_o;
  logic [1:0]                      rvalid_o;
  logic [NBIT_AXI_WIDTH-1:0]       rdata_o;
  logic                            mem_req_o;
  logic                            mem_we_o;
  logic [NBIT_AXI_WIDTH/8-1:0]     mem_be_o;
  logic [NBIT_AXI_WIDTH-1:0]       mem_addr_o;
  logic [NBIT_AXI_WIDTH-1:0]       mem_data_o;
  logic [USER_AXI_WIDTH-1:0]       mem_user_o;
  logic [NBIT_AXI_WIDTH-1:0]       mem_rdata_i;

  // Arbiter view.
  modport slave (
    input  req_i, we_i, lock_i, be_i, addr_i, wdata_i, user_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_be_o,
           mem_addr_o, mem_data_o, mem_user_o
  );

  // Requesters plus downstream memory, as seen from outside the arbiter.
  modport master (
    output req_i, we_i, lock_i, be_i, addr_i, wdata_i, user_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, mem_req_o, mem_we_o, mem_be_o,
           mem_addr_o, mem_data_o, mem_user_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-way round-robin arbiter onto one memory port, with bus locking bounded by
// MAX_HOLD and a one-cycle response tracker.
module mem_port_arbiter #(
  parameter int NBIT_AXI_WIDTH = 64,
  parameter int USER_AXI_WIDTH = 10,
  parameter int MAX_HOLD       = 8
) (
  input logic               clk_i,
  input logic               rst_ni,
  mem_port_arbiter_if.slave bus
);
  localparam int         BE_W       = NBIT_AXI_WIDTH / 8;
  localparam int         DW         = NBIT_AXI_WIDTH;
  localparam int         UW         = USER_AXI_WIDTH;
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       rr_ptr_q, rr_ptr_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic [1:0] rsp_owner_q;

  logic       owner, other;
  logic       do_arb, arb_ptr;
  logic [1:0] gnt_raw, gnt;
  logic       sel, any_gnt;

  assign owner = (state_q == OWN1);
  assign other = ~owner;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    gnt_raw    = 2'b00;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    do_arb     = 1'b0;
    arb_ptr    = rr_ptr_q;

    case (state_q)
      IDLE: do_arb = 1'b1;
      OWN0, OWN1: begin
        if (!bus.lock_i[owner]) begin
          // Owner released the lock: plain arbitration, the other side goes first.
          do_arb   = 1'b1;
          arb_ptr  = other;
          rr_ptr_d = other;
        end else if (hold_cnt_q >= MAX_HOLD_C && bus.req_i[other]) begin
          gnt_raw[other] = 1'b1;
          rr_ptr_d       = owner;
          state_d        = IDLE;
          hold_cnt_d     = 8'd0;
        end else if (bus.req_i[owner]) begin
          gnt_raw[owner] = 1'b1;
          hold_cnt_d     = (hold_cnt_q == 8'hFF) ? 8'hFF : hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_arb) begin
      state_d    = IDLE;
      hold_cnt_d = 8'd0;
      case (bus.req_i)
        2'b01: gnt_raw = 2'b01;
        2'b10: gnt_raw = 2'b10;
        2'b11: begin
          gnt_raw[arb_ptr] = 1'b1;
          rr_ptr_d         = ~arb_ptr;
        end
        default: gnt_raw = 2'b00;
      endcase
      if (gnt_raw[0] && bus.lock_i[0]) begin
        state_d    = OWN0;
        hold_cnt_d = 8'd1;
      end else if (gnt_raw[1] && bus.lock_i[1]) begin
        state_d    = OWN1;
        hold_cnt_d = 8'd1;
      end
    end
  end

  // Nothing leaves the arbiter while reset is held.
  assign gnt     = gnt_raw & {2{rst_ni}};
  assign any_gnt = |gnt;
  assign sel     = gnt[1];

  assign bus.gnt_o      = gnt;
  assign bus.mem_req_o  = any_gnt;
  assign bus.mem_we_o   = |(gnt & bus.we_i);
  assign bus.mem_be_o   = !any_gnt ? '0 : sel ? bus.be_i[2*BE_W-1:BE_W]
                                              : bus.be_i[BE_W-1:0];
  assign bus.mem_addr_o = !any_gnt ? '0 : sel ? bus.addr_i[2*DW-1:DW]
                                              : bus.addr_i[DW-1:0];
  assign bus.mem_data_o = !any_gnt ? '0 : sel ? bus.wdata_i[2*DW-1:DW]
                                              : bus.wdata_i[DW-1:0];
  assign bus.mem_user_o = !any_gnt ? '0 : sel ? bus.user_i[2*UW-1:UW]
                                              : bus.user_i[UW-1:0];

  assign bus.rvalid_o = rsp_owner_q;
  assign bus.rdata_o  = bus.mem_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      hold_cnt_q  <= 8'd0;
      rsp_owner_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      rsp_owner_q <= gnt;
    end
  end
endmodule
